clock_set_ctrl: RTL and testbench

- Controls the three cascaded `counter` instances (seconds, minutes, hours) that make up the digital clock.
- In RUN mode it generates the cascaded enable strobes from the 1 Hz tick.
- In the SET modes it halts timekeeping and turns debounced button pulses into `set`/`set_count` loads on the selected counter.
- It also drives a blink flag for the display and an inactivity timeout that returns the clock to RUN.

---
 rtl/clock_set_ctrl.sv | 175 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Mode/strobe controller for the seconds/minutes/hours counter cascade.
// In RUN it turns the 1 Hz tick into cascaded enable pulses. In the SET modes
// timekeeping halts and btn_inc becomes a single set pulse plus load value for
// the selected counter. It also provides a blink flag and an inactivity timeout
// back to RUN.
// Ports:
//   clk, reset (async, active-low)
//   tick_1hz, btn_mode, btn_inc                   one-cycle input pulses
//   sec_count, min_count, hour_count              current counter values
//   sec_enable, min_enable, hour_enable           registered count enables
//   sec_set, min_set, hour_set, set_count         registered load strobe/value
//   mode (0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC)   registered mode
//   blink                                         registered blink flag
module clock_set_ctrl #(
    parameter int SEC_MAX       = 60,
    parameter int MIN_MAX       = 60,
    parameter int HOUR_MAX      = 24,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [31:0] sec_count,
    input  logic [31:0] min_count,
    input  logic [31:0] hour_count,
    output logic        sec_enable,
    output logic        min_enable,
    output logic        hour_enable,
    output logic        sec_set,
    output logic        min_set,
    output logic        hour_set,
    output logic [31:0] set_count,
    output logic [1:0]  mode,
    output logic        blink
);

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_SEC  = 2'd3;

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);

    // Next field value with wrap; out-of-range inputs also load 0.
    function automatic logic [31:0] next_field(input logic [31:0] value,
                                               input int          max_count);
        logic [31:0] last_v;
        last_v = 32'(max_count - 1);
        if (value >= last_v) begin
            next_field = 32'd0;
        end else begin
            next_field = value + 32'd1;
        end
    endfunction

    logic [1:0]    mode_r,      mode_s;
    logic [TW-1:0] timeout_r,   timeout_s;
    logic          blink_r,     blink_s;
    logic          sec_en_r,    sec_en_s;
    logic          min_en_r,    min_en_s;
    logic          hour_en_r,   hour_en_s;
    logic          sec_set_r,   sec_set_s;
    logic          min_set_r,   min_set_s;
    logic          hour_set_r,  hour_set_s;
    logic [31:0]   set_count_r, set_count_s;
    logic          sec_wrap_s,  min_wrap_s;

    assign sec_wrap_s = (sec_count == 32'(SEC_MAX - 1));
    assign min_wrap_s = (min_count == 32'(MIN_MAX - 1));

    // Next-state and next-output decode; btn_mode has priority over everything.
    always_comb begin
        mode_s      = mode_r;
        timeout_s   = timeout_r;
        blink_s     = blink_r;
        sec_en_s    = 1'b0;
        min_en_s    = 1'b0;
        hour_en_s   = 1'b0;
        sec_set_s   = 1'b0;
        min_set_s   = 1'b0;
        hour_set_s  = 1'b0;
        set_count_s = set_count_r;
        if (btn_mode) begin
            // 2-bit increment gives RUN->HOUR->MIN->SEC->RUN directly.
            mode_s    = mode_r + 2'd1;
            timeout_s = '0;
            blink_s   = 1'b0;
        end else if (mode_r == MODE_RUN) begin
            timeout_s = '0;
            blink_s   = 1'b0;
            sec_en_s  = tick_1hz;
            min_en_s  = tick_1hz && sec_wrap_s;
            hour_en_s = tick_1hz && sec_wrap_s && min_wrap_s;
        end else begin
            if (tick_1hz) begin
                blink_s = ~blink_r;
            end else begin
                blink_s = blink_r;
            end
            if (btn_inc) begin
                // A button press restarts the inactivity window even on a tick.
                timeout_s = '0;
                case (mode_r)
                    MODE_SET_HOUR: begin
                        hour_set_s  = 1'b1;
                        set_count_s = next_field(hour_count, HOUR_MAX);
                    end
                    MODE_SET_MIN: begin
                        min_set_s   = 1'b1;
                        set_count_s = next_field(min_count, MIN_MAX);
                    end
                    MODE_SET_SEC: begin
                        sec_set_s   = 1'b1;
                        set_count_s = next_field(sec_count, SEC_MAX);
                    end
                    default: begin
                        set_count_s = set_count_r;
                    end
                endcase
            end else if (tick_1hz) begin
                if (timeout_r >= TIMEOUT_LAST) begin
                    mode_s    = MODE_RUN;
                    timeout_s = '0;
                    blink_s   = 1'b0;
                end else begin
                    timeout_s = timeout_r + TW'(1);
                end
            end else begin
                timeout_s = timeout_r;
            end
        end
    end

    // State and output registers; reset drops any pending strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r      <= MODE_RUN;
            timeout_r   <= '0;
            blink_r     <= 1'b0;
            sec_en_r    <= 1'b0;
            min_en_r    <= 1'b0;
            hour_en_r   <= 1'b0;
            sec_set_r   <= 1'b0;
            min_set_r   <= 1'b0;
            hour_set_r  <= 1'b0;
            set_count_r <= 32'd0;
        end else begin
            mode_r      <= mode_s;
            timeout_r   <= timeout_s;
            blink_r     <= blink_s;
            sec_en_r    <= sec_en_s;
            min_en_r    <= min_en_s;
            hour_en_r   <= hour_en_s;
            sec_set_r   <= sec_set_s;
            min_set_r   <= min_set_s;
            hour_set_r  <= hour_set_s;
            set_count_r <= set_count_s;
        end
    end

    assign mode        = mode_r;
    assign blink       = blink_r;
    assign sec_enable  = sec_en_r;
    assign min_enable  = min_en_r;
    assign hour_enable = hour_en_r;
    assign sec_set     = sec_set_r;
    assign min_set     = min_set_r;
    assign hour_set    = hour_set_r;
    assign set_count   = set_count_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: reset, cascade, mode cycling, increment
// wrap, collision, timeout and asynchronous reset during a set pulse.
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [31:0] sec_count = 32'd0;
    logic [31:0] min_count = 32'd0;
    logic [31:0] hour_count = 32'd0;
    logic        sec_enable, min_enable, hour_enable;
    logic        sec_set, min_set, hour_set;
    logic [31:0] set_count;
    logic [1:0]  mode;
    logic        blink;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_count(sec_count), .min_count(min_count), .hour_count(hour_count),
        .sec_enable(sec_enable), .min_enable(min_enable), .hour_enable(hour_enable),
        .sec_set(sec_set), .min_set(min_set), .hour_set(hour_set),
        .set_count(set_count), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs at negedge; return 1 time unit after the edge.
    task automatic drive(input logic m, input logic i, input logic t);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        tick_1hz = t;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({mode, blink, sec_enable, min_enable, hour_enable, sec_set, min_set, hour_set} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {mode, blink, sec_enable, min_enable, hour_enable, sec_set, min_set, hour_set});
        end
        checks++;
        if (set_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_set_count got %0d exp 0", set_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_cascade();
        sec_count = 32'd59; min_count = 32'd59; hour_count = 32'd5;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if ({sec_enable, min_enable, hour_enable} !== 3'b111) begin
            errors++;
            $display("FAIL cascade_full got %b exp 111", {sec_enable, min_enable, hour_enable});
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({sec_enable, min_enable, hour_enable} !== 3'b000) begin
            errors++;
            $display("FAIL cascade_one_cycle got %b exp 000", {sec_enable, min_enable, hour_enable});
        end
        sec_count = 32'd30;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if ({sec_enable, min_enable, hour_enable} !== 3'b100) begin
            errors++;
            $display("FAIL cascade_sec_only got %b exp 100", {sec_enable, min_enable, hour_enable});
        end
        sec_count = 32'd59; min_count = 32'd30;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if ({sec_enable, min_enable, hour_enable} !== 3'b110) begin
            errors++;
            $display("FAIL cascade_sec_min got %b exp 110", {sec_enable, min_enable, hour_enable});
        end
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if ({sec_set, min_set, hour_set, mode} !== 5'd0) begin
            errors++;
            $display("FAIL run_ignores_inc got %b exp 0", {sec_set, min_set, hour_set, mode});
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode [4];
        exp_mode[0] = 2'd1; exp_mode[1] = 2'd2; exp_mode[2] = 2'd3; exp_mode[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (mode !== exp_mode[k]) begin
                errors++;
                $display("FAIL mode_step%0d got %0d exp %0d", k, mode, exp_mode[k]);
            end
            if (k < 3) begin
                drive(1'b0, 1'b0, 1'b1);
                checks++;
                if ({sec_enable, min_enable, hour_enable, blink} !== 4'b0001) begin
                    errors++;
                    $display("FAIL set_tick%0d got %b exp 0001", k, {sec_enable, min_enable, hour_enable, blink});
                end
            end
        end
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_run got %b exp 0", blink);
        end
    endtask

    task automatic test_increment();
        hour_count = 32'd23; min_count = 32'd12; sec_count = 32'd70;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if ({hour_set, min_set, sec_set} !== 3'b100 || set_count !== 32'd0) begin
            errors++;
            $display("FAIL hour_wrap got sets %b cnt %0d exp 100 cnt 0", {hour_set, min_set, sec_set}, set_count);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (hour_set !== 1'b0) begin
            errors++;
            $display("FAIL hour_set_one_cycle got %b exp 0", hour_set);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if ({hour_set, min_set, sec_set} !== 3'b010 || set_count !== 32'd13) begin
            errors++;
            $display("FAIL min_inc got sets %b cnt %0d exp 010 cnt 13", {hour_set, min_set, sec_set}, set_count);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (min_set !== 1'b0 || set_count !== 32'd13) begin
            errors++;
            $display("FAIL set_count_hold got set %b cnt %0d exp 0 cnt 13", min_set, set_count);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if ({hour_set, min_set, sec_set} !== 3'b001 || set_count !== 32'd0) begin
            errors++;
            $display("FAIL sec_illegal got sets %b cnt %0d exp 001 cnt 0", {hour_set, min_set, sec_set}, set_count);
        end
        sec_count = 32'd58;
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (sec_set !== 1'b1 || set_count !== 32'd59) begin
            errors++;
            $display("FAIL sec_inc got set %b cnt %0d exp 1 cnt 59", sec_set, set_count);
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL back_to_run got %0d exp 0", mode);
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (mode !== 2'd2 || {hour_set, min_set, sec_set} !== 3'b000) begin
            errors++;
            $display("FAIL collision got mode %0d sets %b exp mode 2 sets 000", mode, {hour_set, min_set, sec_set});
        end
    endtask

    task automatic test_timeout();
        // Already in SET_MIN with blink cleared by the mode change.
        min_count = 32'd12;
        for (int k = 0; k < 9; k++) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (mode !== 2'd2 || blink !== 1'b1) begin
            errors++;
            $display("FAIL pre_press got mode %0d blink %b exp 2 1", mode, blink);
        end
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (min_set !== 1'b1 || set_count !== 32'd13) begin
            errors++;
            $display("FAIL press got set %b cnt %0d exp 1 13", min_set, set_count);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_toggle got %b exp 0", blink);
        end
        for (int k = 1; k < 9; k++) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (mode !== 2'd2 || blink !== 1'b0) begin
            errors++;
            $display("FAIL tick9 got mode %0d blink %b exp 2 0", mode, blink);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (mode !== 2'd0 || blink !== 1'b0 || sec_enable !== 1'b0) begin
            errors++;
            $display("FAIL tick10 got mode %0d blink %b en %b exp 0 0 0", mode, blink, sec_enable);
        end
        sec_count = 32'd10;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (sec_enable !== 1'b1) begin
            errors++;
            $display("FAIL resume got %b exp 1", sec_enable);
        end
    endtask

    task automatic test_reset_mid();
        hour_count = 32'd5;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (hour_set !== 1'b1 || set_count !== 32'd6) begin
            errors++;
            $display("FAIL pre_reset got set %b cnt %0d exp 1 6", hour_set, set_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mode, hour_set, blink} !== 4'd0 || set_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got %b cnt %0d exp 0 0", {mode, hour_set, blink}, set_count);
        end
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (sec_enable !== 1'b1 || mode !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_tick got en %b mode %0d exp 1 0", sec_enable, mode);
        end
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_mode_cycle();
        test_increment();
        test_collision();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
